// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP payload packer.
package udp_pkg;

  localparam int SEQ_BYTES       = 4;
  localparam int MAX_UDP_PAYLOAD = 1472;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ARM,
    R_SEND,
    R_RELEASE
  } rd_state_t;

  // Sequence-number prefix is sent MSB first.
  function automatic logic [7:0] seq_byte(input logic [31:0] seq, input logic [1:0] idx);
    case (idx)
      2'd0:    return seq[31:24];
      2'd1:    return seq[23:16];
      2'd2:    return seq[15:8];
      default: return seq[7:0];
    endcase
  endfunction

endpackage

// File: rtl/udp_payload_packer_bank_ram.sv
// Ping-pong bank storage: 16-bit word write port, byte-wide synchronous read port.
module pp_bank_ram #(
  parameter int WORDS = 1024,
  parameter int WAW   = $clog2(WORDS)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [WAW-1:0] wr_addr,
  input  logic [15:0]    wr_data,
  input  logic [WAW:0]   rd_addr,
  output logic [7:0]     rd_data
);

  logic [15:0] mem [WORDS];
  logic [15:0] q;
  logic        lsb;

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    q   <= mem[rd_addr[WAW:1]];
    lsb <= rd_addr[0];
  end

  // Even byte address holds the sample MSB.
  assign rd_data = lsb ? q[7:0] : q[15:8];

endmodule

// File: rtl/udp_payload_packer.sv
// Packs 16-bit samples into two ping-pong banks and streams each committed bank,
// prefixed by a 32-bit frame sequence number, to the UDP frame sender.
module udp_payload_packer
  import udp_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 1024,
  parameter int TIMEOUT_CYC   = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_sample,
  input  logic        i_sample_vl,
  output logic        o_sample_rdy,
  input  logic        i_flush,
  output logic [7:0]  o_data,
  output logic [15:0] o_data_len,
  input  logic        i_rd,
  output logic        o_enable,
  input  logic        i_ready,
  output logic [31:0] o_frame_cnt,
  output logic [15:0] o_drop_cnt
);

  localparam int WAW        = $clog2(PAYLOAD_BYTES);
  localparam int BAW        = WAW + 1;
  localparam int TW         = $clog2(TIMEOUT_CYC + 1);
  localparam int HALF_WORDS = PAYLOAD_BYTES / 2;

  // write side
  logic [1:0]       bank_full;
  logic [1:0][15:0] bank_len;
  logic             wr_bank;
  logic [15:0]      wr_ptr, ptr_nxt;
  logic [TW-1:0]    tmo_cnt;
  logic             accept, fill, tmo_hit, commit;
  logic [WAW-1:0]   wr_addr;

  // read side
  rd_state_t        state, state_nxt;
  logic             rd_bank;
  logic             launch, release_bank;
  logic [31:0]      seq_q, frame_cnt;
  logic [15:0]      rd_idx, idx_nxt, rd_off, data_len, drop_cnt;
  logic [BAW-1:0]   rd_addr;
  logic [7:0]       ram_q;

  assign o_sample_rdy = ~bank_full[wr_bank];
  assign accept       = i_sample_vl & o_sample_rdy;
  assign ptr_nxt      = wr_ptr + (accept ? 16'd2 : 16'd0);
  assign fill         = accept && (ptr_nxt == 16'(PAYLOAD_BYTES));
  assign tmo_hit      = (wr_ptr != 16'd0) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  // A flush that coincides with a sample takes the sample along; a filling
  // sample already commits, so the flush adds nothing.
  assign commit       = fill | ((i_flush | tmo_hit) & (ptr_nxt != 16'd0));
  assign wr_addr      = WAW'(wr_bank ? HALF_WORDS : 0) + WAW'(wr_ptr >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full <= '0;
      bank_len  <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_ptr    <= '0;
      tmo_cnt   <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (commit) begin
        bank_full[wr_bank] <= 1'b1;
        bank_len[wr_bank]  <= ptr_nxt;
        wr_ptr             <= '0;
        wr_bank            <= ~wr_bank;
      end else begin
        wr_ptr <= ptr_nxt;
      end
      if (commit || accept || wr_ptr == 16'd0) tmo_cnt <= '0;
      else                                     tmo_cnt <= tmo_cnt + 1'b1;
      // Release always targets the other bank from any concurrent commit.
      if (release_bank) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= ~rd_bank;
        frame_cnt          <= frame_cnt + 32'd1;
      end
      if (i_sample_vl && !o_sample_rdy && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= R_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_enable     = 1'b0;
    release_bank = 1'b0;
    launch       = 1'b0;
    idx_nxt      = rd_idx;
    case (state)
      R_IDLE: begin
        if (bank_full[rd_bank] && i_ready) begin
          state_nxt = R_ARM;
          launch    = 1'b1;
        end
      end
      R_ARM: begin
        o_enable = 1'b1;
        if (!i_ready) state_nxt = R_SEND;
      end
      R_SEND: begin
        if (i_rd)    idx_nxt   = rd_idx + 16'd1;
        if (i_ready) state_nxt = R_RELEASE;
      end
      R_RELEASE: begin
        release_bank = 1'b1;
        state_nxt    = R_IDLE;
      end
      default: state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q    <= '0;
      data_len <= '0;
      rd_idx   <= '0;
    end else if (launch) begin
      seq_q    <= frame_cnt;
      data_len <= 16'(SEQ_BYTES) + bank_len[rd_bank];
      rd_idx   <= '0;
    end else begin
      rd_idx   <= idx_nxt;
    end
  end

  // Look-ahead read address: the RAM fetches the byte for the index that
  // rd_idx takes at this edge, so every i_rd cycle sees a fresh byte.
  assign rd_off  = idx_nxt - 16'(SEQ_BYTES);
  assign rd_addr = BAW'(rd_bank ? PAYLOAD_BYTES : 0) + BAW'(rd_off);

  pp_bank_ram #(
    .WORDS (PAYLOAD_BYTES)
  ) u_ram (
    .clk     (clk),
    .we      (accept),
    .wr_addr (wr_addr),
    .wr_data (i_sample),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  always_comb begin
    o_data = 8'h00;
    if (rd_idx < 16'(SEQ_BYTES)) o_data = seq_byte(seq_q, rd_idx[1:0]);
    else if (rd_idx < data_len)  o_data = ram_q;
  end

  assign o_data_len  = data_len;
  assign o_frame_cnt = frame_cnt;
  assign o_drop_cnt  = drop_cnt;

endmodule
